// File: rtl/trap_sequencer.sv
// Machine-mode trap / mret sequencer: arbitrates trap sources, writes mepc, mcause
// and mstatus through the CSR write port, then issues a one-cycle redirect.
module trap_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        exception,
    input  logic [3:0]  exception_cause,
    input  logic        mret,
    input  logic        external_interrupt,
    input  logic        timer_interrupt,
    input  logic        software_interrupt,
    input  logic [31:0] current_pc,
    input  logic [31:0] csr_mstatus,
    input  logic [31:0] csr_mie,
    input  logic [31:0] csr_mtvec,
    input  logic [31:0] csr_mepc,
    output logic [11:0] csr_number,
    output logic [1:0]  csr_access_type,
    output logic [31:0] csr_in,
    output logic        stall,
    output logic        redirect,
    output logic [31:0] redirect_pc
);
    localparam logic [1:0]  CSR_READ_ONLY = 2'd0;
    localparam logic [1:0]  CSR_WRITE     = 2'd1;
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAVE_EPC,
        S_SAVE_CAUSE,
        S_SAVE_STATUS,
        S_RESTORE_STATUS,
        S_REDIRECT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] old_status_q, old_status_d;
    logic        is_mret_q, is_mret_d;

    logic [11:0] csr_number_q, csr_number_d;
    logic [1:0]  csr_access_type_q, csr_access_type_d;
    logic [31:0] csr_in_q, csr_in_d;
    logic        redirect_q, redirect_d;

    logic        take_ext, take_sw, take_tim, take_trap, accept;
    logic [31:0] trap_status, mret_status, vec_base;

    assign take_ext  = csr_mstatus[3] & csr_mie[11] & external_interrupt;
    assign take_sw   = csr_mstatus[3] & csr_mie[3]  & software_interrupt;
    assign take_tim  = csr_mstatus[3] & csr_mie[7]  & timer_interrupt;
    assign take_trap = exception | take_ext | take_sw | take_tim;
    assign accept    = (state_q == S_IDLE) & (take_trap | mret);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= S_IDLE;
            epc_q             <= '0;
            cause_q           <= '0;
            old_status_q      <= '0;
            is_mret_q         <= 1'b0;
            csr_number_q      <= '0;
            csr_access_type_q <= CSR_READ_ONLY;
            csr_in_q          <= '0;
            redirect_q        <= 1'b0;
        end else begin
            state_q           <= state_d;
            epc_q             <= epc_d;
            cause_q           <= cause_d;
            old_status_q      <= old_status_d;
            is_mret_q         <= is_mret_d;
            csr_number_q      <= csr_number_d;
            csr_access_type_q <= csr_access_type_d;
            csr_in_q          <= csr_in_d;
            redirect_q        <= redirect_d;
        end
    end

    // Next state and latches; priority exception > ext > sw > timer > mret.
    always_comb begin
        state_d      = state_q;
        epc_d        = epc_q;
        cause_d      = cause_q;
        old_status_d = old_status_q;
        is_mret_d    = is_mret_q;
        case (state_q)
            S_IDLE: begin
                if (take_trap) begin
                    state_d      = S_SAVE_EPC;
                    epc_d        = current_pc;
                    old_status_d = csr_mstatus;
                    is_mret_d    = 1'b0;
                    if (exception)     cause_d = {28'd0, exception_cause};
                    else if (take_ext) cause_d = {1'b1, 27'd0, 4'd11};
                    else if (take_sw)  cause_d = {1'b1, 27'd0, 4'd3};
                    else               cause_d = {1'b1, 27'd0, 4'd7};
                end else if (mret) begin
                    state_d      = S_RESTORE_STATUS;
                    old_status_d = csr_mstatus;
                    is_mret_d    = 1'b1;
                end
            end
            S_SAVE_EPC:       state_d = S_SAVE_CAUSE;
            S_SAVE_CAUSE:     state_d = S_SAVE_STATUS;
            S_SAVE_STATUS:    state_d = S_REDIRECT;
            S_RESTORE_STATUS: state_d = S_REDIRECT;
            S_REDIRECT:       state_d = S_IDLE;
            default:          state_d = S_IDLE;
        endcase
    end

    always_comb begin
        trap_status        = old_status_d;
        trap_status[7]     = old_status_d[3];
        trap_status[3]     = 1'b0;
        trap_status[12:11] = 2'b11;
        mret_status        = old_status_d;
        mret_status[3]     = old_status_d[7];
        mret_status[7]     = 1'b1;
        mret_status[12:11] = 2'b11;
    end

    // Outputs are decoded from the upcoming state so the write port is registered.
    always_comb begin
        csr_number_d      = '0;
        csr_access_type_d = CSR_READ_ONLY;
        csr_in_d          = '0;
        redirect_d        = 1'b0;
        case (state_d)
            S_SAVE_EPC: begin
                csr_number_d      = CSR_MEPC;
                csr_access_type_d = CSR_WRITE;
                csr_in_d          = epc_d;
            end
            S_SAVE_CAUSE: begin
                csr_number_d      = CSR_MCAUSE;
                csr_access_type_d = CSR_WRITE;
                csr_in_d          = cause_d;
            end
            S_SAVE_STATUS: begin
                csr_number_d      = CSR_MSTATUS;
                csr_access_type_d = CSR_WRITE;
                csr_in_d          = trap_status;
            end
            S_RESTORE_STATUS: begin
                csr_number_d      = CSR_MSTATUS;
                csr_access_type_d = CSR_WRITE;
                csr_in_d          = mret_status;
            end
            S_REDIRECT: redirect_d = 1'b1;
            default: ;
        endcase
    end

    // Target is computed live so it sees the CSR values committed during the sequence.
    assign vec_base = {csr_mtvec[31:2], 2'b00};
    always_comb begin
        redirect_pc = '0;
        if (state_q == S_REDIRECT) begin
            if (is_mret_q)
                redirect_pc = csr_mepc;
            else if ((csr_mtvec[1:0] == 2'b01) && cause_q[31])
                redirect_pc = vec_base + {26'd0, cause_q[3:0], 2'b00};
            else
                redirect_pc = vec_base;
        end
    end

    assign stall           = (state_q != S_IDLE) | accept;
    assign redirect        = redirect_q;
    assign csr_number      = csr_number_q;
    assign csr_access_type = csr_access_type_q;
    assign csr_in          = csr_in_q;

    logic unused_ok;
    assign unused_ok = ^{csr_mie[31:12], csr_mie[10:8], csr_mie[6:4], csr_mie[2:0],
                         cause_q[30:4]};
endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer with hand-computed expectations.
module tb_trap_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        exception;
    logic [3:0]  exception_cause;
    logic        mret;
    logic        external_interrupt, timer_interrupt, software_interrupt;
    logic [31:0] current_pc, csr_mstatus, csr_mie, csr_mtvec, csr_mepc;
    logic [11:0] csr_number;
    logic [1:0]  csr_access_type;
    logic [31:0] csr_in;
    logic        stall, redirect;
    logic [31:0] redirect_pc;

    int n_cmp = 0;
    int n_err = 0;

    trap_sequencer dut (
        .clk(clk), .reset(reset), .exception(exception), .exception_cause(exception_cause),
        .mret(mret), .external_interrupt(external_interrupt), .timer_interrupt(timer_interrupt),
        .software_interrupt(software_interrupt), .current_pc(current_pc),
        .csr_mstatus(csr_mstatus), .csr_mie(csr_mie), .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
        .csr_number(csr_number), .csr_access_type(csr_access_type), .csr_in(csr_in),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_write(input string tag, input logic [11:0] num, input logic [31:0] data);
        chk({tag, ".type"}, {30'd0, csr_access_type}, 32'd1);
        chk({tag, ".num"}, {20'd0, csr_number}, {20'd0, num});
        chk({tag, ".data"}, csr_in, data);
        chk({tag, ".stall"}, {31'd0, stall}, 32'd1);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".stall"}, {31'd0, stall}, 32'd0);
        chk({tag, ".redir"}, {31'd0, redirect}, 32'd0);
        chk({tag, ".type"}, {30'd0, csr_access_type}, 32'd0);
        chk({tag, ".num"}, {20'd0, csr_number}, 32'd0);
    endtask

    task automatic chk_redirect(input string tag, input logic [31:0] pc);
        chk({tag, ".redir"}, {31'd0, redirect}, 32'd1);
        chk({tag, ".pc"}, redirect_pc, pc);
        chk({tag, ".stall"}, {31'd0, stall}, 32'd1);
        chk({tag, ".type"}, {30'd0, csr_access_type}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; exception = 1'b0; exception_cause = 4'd0; mret = 1'b0;
        external_interrupt = 1'b0; timer_interrupt = 1'b0; software_interrupt = 1'b0;
        current_pc = '0; csr_mstatus = '0; csr_mie = '0; csr_mtvec = '0; csr_mepc = '0;
        tick(); tick();
        chk_quiet("reset");
        chk("reset.pc", redirect_pc, 32'd0);
        chk("reset.data", csr_in, 32'd0);
        reset = 1'b0;

        // Direct exception
        csr_mtvec = 32'h200; csr_mstatus = 32'h8; current_pc = 32'h100;
        exception = 1'b1; exception_cause = 4'd2;
        #1 chk("exc.N.stall", {31'd0, stall}, 32'd1);
        tick(); chk_write("exc.epc", 12'h341, 32'h100);
        tick(); chk_write("exc.cause", 12'h342, 32'h2);
        tick(); chk_write("exc.status", 12'h300, 32'h1880);
        csr_mstatus = 32'h1880;
        tick(); chk_redirect("exc.redir", 32'h200);
        exception = 1'b0;
        tick(); chk_quiet("exc.done");
        chk("exc.done.pc", redirect_pc, 32'd0);

        // Vectored timer interrupt
        csr_mtvec = 32'h201; csr_mie = 32'h80; csr_mstatus = 32'h8; current_pc = 32'h300;
        timer_interrupt = 1'b1;
        #1 chk("tim.N.stall", {31'd0, stall}, 32'd1);
        tick(); chk_write("tim.epc", 12'h341, 32'h300);
        tick(); chk_write("tim.cause", 12'h342, 32'h8000_0007);
        tick(); chk_write("tim.status", 12'h300, 32'h1880);
        csr_mstatus = 32'h1880;
        tick(); chk_redirect("tim.redir", 32'h21C);
        tick(); chk_quiet("tim.notretaken");
        timer_interrupt = 1'b0;

        // Masked, then enabled: external wins
        csr_mie = 32'h888; csr_mstatus = 32'h1880;
        external_interrupt = 1'b1; timer_interrupt = 1'b1; software_interrupt = 1'b1;
        #1 chk("mask.stall", {31'd0, stall}, 32'd0);
        tick(); chk_quiet("mask.nowrite");
        csr_mstatus = 32'h1888; current_pc = 32'h340;
        #1 chk("ext.N.stall", {31'd0, stall}, 32'd1);
        tick(); chk_write("ext.epc", 12'h341, 32'h340);
        tick(); chk_write("ext.cause", 12'h342, 32'h8000_000B);
        tick(); chk_write("ext.status", 12'h300, 32'h1880);
        csr_mstatus = 32'h1880;
        tick(); chk_redirect("ext.redir", 32'h22C);
        external_interrupt = 1'b0; timer_interrupt = 1'b0; software_interrupt = 1'b0;
        tick(); chk_quiet("ext.done");

        // Exception beats simultaneous software/timer interrupts
        csr_mstatus = 32'h1888; current_pc = 32'h400;
        exception = 1'b1; exception_cause = 4'd4;
        software_interrupt = 1'b1; timer_interrupt = 1'b1;
        tick(); chk_write("pri.epc", 12'h341, 32'h400);
        tick(); chk_write("pri.cause", 12'h342, 32'h4);
        tick(); chk_write("pri.status", 12'h300, 32'h1880);
        csr_mstatus = 32'h1880;
        tick(); chk_redirect("pri.redir", 32'h200);
        exception = 1'b0;
        tick(); chk_quiet("pri.noint");
        tick(); chk_quiet("pri.noint2");
        software_interrupt = 1'b0; timer_interrupt = 1'b0;

        // mret
        csr_mepc = 32'h104; mret = 1'b1;
        #1 chk("mret.N.stall", {31'd0, stall}, 32'd1);
        tick(); chk_write("mret.status", 12'h300, 32'h1888);
        csr_mstatus = 32'h1888;
        tick(); chk_redirect("mret.redir", 32'h104);
        mret = 1'b0;
        tick(); chk_quiet("mret.done");

        // Reset during SAVE_CAUSE
        csr_mtvec = 32'h200; csr_mstatus = 32'h8; current_pc = 32'h500;
        exception = 1'b1; exception_cause = 4'd5;
        tick(); chk_write("rst.epc", 12'h341, 32'h500);
        tick(); chk_write("rst.cause", 12'h342, 32'h5);
        reset = 1'b1; exception = 1'b0;
        tick(); chk_quiet("rst.after");
        reset = 1'b0;
        tick(); chk_quiet("rst.nostatus");
        current_pc = 32'h600; exception = 1'b1; exception_cause = 4'd6;
        #1 chk("rst.fresh.stall", {31'd0, stall}, 32'd1);
        tick(); chk_write("rst.fresh.epc", 12'h341, 32'h600);
        tick(); chk_write("rst.fresh.cause", 12'h342, 32'h6);
        tick(); chk_write("rst.fresh.status", 12'h300, 32'h1880);
        csr_mstatus = 32'h1880;
        tick(); chk_redirect("rst.fresh.redir", 32'h200);
        exception = 1'b0;
        tick(); chk_quiet("rst.fresh.done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
